disp_mem_writer: RTL
====================

// Module: disp_mem_writer
// PURPOSE
//  Write-side counterpart of the display scan address generator. It accepts a burst of
//  digit/segment words over a valid/ready handshake and writes them into display RAM
//  at consecutive addresses within the window [begin..end]. Once the burst completes,
//  it publishes the new window to the scanner at a frame boundary (scanner overflow),
//  so the visible frame never mixes old and new data.
// PARAMETERS
//  WIDTH         4   address width; address arithmetic is mod 2^WIDTH
//  DATA_WIDTH    8   RAM word width
//  RST_ADDR_END  5   reset value of o_win_end; o_win_begin resets to 0
// PORTS
//  i_clk          in   1           clock, rising edge
//  i_rst_n        in   1           synchronous, active-low reset
//  i_start        in   1           begin burst; sampled only in IDLE
//  i_addr_begin   in   WIDTH       first write address, latched on accepted i_start
//  i_addr_end     in   WIDTH       last write address, latched on accepted i_start
//  i_valid        in   1           i_data valid
//  i_data         in   DATA_WIDTH  word to write
//  o_ready        out  1           writer accepts i_data this cycle
//  o_we           out  1           RAM write enable (1-cycle pulse per word)
//  o_waddr        out  WIDTH       RAM write address
//  o_wdata        out  DATA_WIDTH  RAM write data
//  i_rd_overflow  in   1           scanner frame-boundary strobe
//  o_win_begin    out  WIDTH       published scan window start
//  o_win_end      out  WIDTH       published scan window end
//  o_busy         out  1           high in any state except IDLE
//  o_done         out  1           1-cycle pulse when the window is published
// BEHAVIOUR
//  Reset: state=IDLE; o_ready=0, o_we=0, o_waddr=0, o_wdata=0, o_busy=0, o_done=0,
//   o_win_begin=0, o_win_end=RST_ADDR_END. A reset mid-burst abandons the burst;
//   words already written stay in RAM, and the window returns to its reset values.
//  FSM: IDLE -> WRITE on i_start. In IDLE, latch begin/end and set ptr<=begin.
//   In WRITE: o_ready=1 (a registered state decode; no combinational path from i_valid).
//   A transfer occurs when i_valid & o_ready. On the next cycle: o_we=1, o_waddr=ptr,
//   o_wdata=i_data. Write latency is 1 cycle.
//   On a transfer with ptr==end -> SYNC (o_ready=0 from the next cycle).
//   Otherwise ptr<=ptr+1 mod 2^WIDTH, so begin>end wraps through 2^WIDTH-1 -> 0.
//   begin==end is a 1-word burst.
//   SYNC: wait for the publish condition. Then o_win_begin/o_win_end <= latched values,
//   o_done=1 for one cycle, and -> IDLE.
//  Simultaneous events: i_start outside IDLE is ignored. A transfer never coincides
//   with SYNC. i_rd_overflow outside SYNC is ignored.
//  The RAM sees the final write before or with o_done; the last o_we pulse precedes
//   o_done by at least 1 cycle.
// CONFIGURATION
//  DISP_WR_FRAME_SYNC_EN defined: SYNC waits for i_rd_overflow==1, sampled in SYNC.
//   Publishing happens in the cycle after the sample.
//  Not defined: SYNC publishes unconditionally in the cycle after entry, which
//   allows tearing. i_rd_overflow is then unused.
// STRUCTURE
//  Shared include disp_defs.vh: FSM state localparams (IDLE, WRITE, SYNC; 2-bit),
//   default widths.
//  One sub-module, disp_wr_ptr: a WIDTH-bit loadable pointer with load/inc/enable
//   and an ==end compare output. FSM, output registers and window registers live
//   at the top level.
// TESTING
//  1 begin=2,end=5, 4 words A0..A3, valid held high -> o_we at waddr 2,3,4,5 with
//    A0..A3 on consecutive cycles; o_ready low after 4th transfer.
//  2 SYNC_EN on, i_rd_overflow pulsed 10 cycles after burst -> o_done and
//    win_begin=2/win_end=5 exactly 1 cycle after the pulse, not earlier.
//  3 begin=14,end=1,WIDTH=4 -> writes at 14,15,0,1; window 14/1 published.
//  4 valid toggled 1,0,1,0 with data B0,B1 -> exactly 2 writes, no duplicates, addr
//    increments only on transfer.
//  5 i_start pulsed during WRITE with begin=9 -> ignored; burst completes with
//    original window.
//  6 i_rst_n low after 2 of 4 words -> next cycle o_we=0, o_busy=0, window=0/5; new
//    i_start works.

Source files
------------

// File: rtl/disp_mem_writer_pkg.sv
// Shared types and default sizes for the display-RAM burst writer.
package disp_mem_writer_pkg;

  localparam int DEF_WIDTH        = 4;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_RST_ADDR_END = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SYNC  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/disp_mem_writer_wr_ptr.sv
// Loadable write-address pointer with increment, enable and end-of-window compare.
module disp_wr_ptr
  import disp_mem_writer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_end,
  output logic [WIDTH-1:0] o_ptr,
  output logic             o_at_end
);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  // Load takes priority; the increment wraps naturally at 2^WIDTH.
  always_comb begin
    ptr_d = ptr_q;
    if (i_en) begin
      if (i_load) begin
        ptr_d = i_load_val;
      end else if (i_inc) begin
        ptr_d = ptr_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr    = ptr_q;
  assign o_at_end = (ptr_q == i_end);

endmodule

// File: rtl/disp_mem_writer.sv
// Burst writer into display RAM; publishes the new scan window once the burst is written.
// Define DISP_WR_FRAME_SYNC_EN to hold publication until the scanner's frame-boundary strobe.
module disp_mem_writer
  import disp_mem_writer_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int RST_ADDR_END = DEF_RST_ADDR_END
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_addr_begin,
  input  logic [WIDTH-1:0]      i_addr_end,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_we,
  output logic [WIDTH-1:0]      o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_rd_overflow,
  output logic [WIDTH-1:0]      o_win_begin,
  output logic [WIDTH-1:0]      o_win_end,
  output logic                  o_busy,
  output logic                  o_done
);

  wr_state_e             state_q, state_d;
  logic [WIDTH-1:0]      begin_q, begin_d;
  logic [WIDTH-1:0]      end_q, end_d;
  logic [WIDTH-1:0]      waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0]      win_begin_q, win_begin_d;
  logic [WIDTH-1:0]      win_end_q, win_end_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;

  logic                  xfer;
  logic                  publish;
  logic                  ptr_load;
  logic                  ptr_inc;
  logic                  at_end;
  logic [WIDTH-1:0]      ptr;

  // Ready is a pure state decode, so a transfer never depends combinationally on o_ready logic.
  assign xfer     = i_valid && (state_q == ST_WRITE);
  assign ptr_load = (state_q == ST_IDLE) && i_start;
  assign ptr_inc  = xfer && !at_end;

`ifdef DISP_WR_FRAME_SYNC_EN
  assign publish = (state_q == ST_SYNC) && i_rd_overflow;
`else
  logic unused_rd_overflow;
  assign unused_rd_overflow = i_rd_overflow;
  assign publish = (state_q == ST_SYNC);
`endif

  disp_wr_ptr #(
    .WIDTH(WIDTH)
  ) u_ptr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (ptr_load || ptr_inc),
    .i_load    (ptr_load),
    .i_inc     (ptr_inc),
    .i_load_val(i_addr_begin),
    .i_end     (end_q),
    .o_ptr     (ptr),
    .o_at_end  (at_end)
  );

  always_comb begin
    state_d     = state_q;
    begin_d     = begin_q;
    end_d       = end_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    win_begin_d = win_begin_q;
    win_end_d   = win_end_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          begin_d = i_addr_begin;
          end_d   = i_addr_end;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (xfer) begin
          we_d    = 1'b1;
          waddr_d = ptr;
          wdata_d = i_data;
          if (at_end) begin
            state_d = ST_SYNC;
          end
        end
      end
      ST_SYNC: begin
        if (publish) begin
          win_begin_d = begin_q;
          win_end_d   = end_q;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      begin_q     <= '0;
      end_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      win_begin_q <= '0;
      win_end_q   <= WIDTH'(RST_ADDR_END);
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      begin_q     <= begin_d;
      end_q       <= end_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      win_begin_q <= win_begin_d;
      win_end_q   <= win_end_d;
      done_q      <= done_d;
    end
  end

  assign o_ready     = (state_q == ST_WRITE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_we        = we_q;
  assign o_waddr     = waddr_q;
  assign o_wdata     = wdata_q;
  assign o_win_begin = win_begin_q;
  assign o_win_end   = win_end_q;
  assign o_done      = done_q;

endmodule
